// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO results, pipeline stall and flush.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             flush_i,
  output logic             stall_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             div_zero_o
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic             is_div;
  logic             neg_res;
  logic             neg_rem;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH-1:0] upper;
  logic [WIDTH-1:0] lower;

  logic             accept;
  logic             is_signed;
  logic             a_neg;
  logic             b_neg;
  logic             div0;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     trial;
  logic [WIDTH-1:0]   nxt_upper;
  logic [WIDTH-1:0]   nxt_lower;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic [2*WIDTH-1:0] prod;

  always_comb begin
    accept    = start_i && !flush_i && (state != RUN);
    is_signed = !op_i[0];
    a_neg     = is_signed && a_i[WIDTH-1];
    b_neg     = is_signed && b_i[WIDTH-1];
    a_mag     = a_neg ? -a_i : a_i;
    b_mag     = b_neg ? -b_i : b_i;
    div0      = op_i[1] && (b_i == '0);
    stall_o   = (state == RUN) || accept;
  end

  // upper/lower are shared: {partial product, multiplier} for multiply,
  // {partial remainder, dividend shifting into quotient} for divide.
  // The remainder invariant (rem < divisor) makes trial[WIDTH] a pure borrow flag.
  always_comb begin
    mul_sum = {1'b0, upper} + (lower[0] ? {1'b0, opnd} : '0);
    rem_sh  = {upper, lower[WIDTH-1]};
    trial   = rem_sh - {1'b0, opnd};
    if (is_div) begin
      nxt_upper = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
      nxt_lower = {lower[WIDTH-2:0], ~trial[WIDTH]};
    end else begin
      nxt_upper = mul_sum[WIDTH:1];
      nxt_lower = {mul_sum[0], lower[WIDTH-1:1]};
    end
    prod = {nxt_upper, nxt_lower};
    if (neg_res) begin
      prod = -prod;
    end
    quo = neg_res ? -nxt_lower : nxt_lower;
    rem = neg_rem ? -nxt_upper : nxt_upper;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      div_zero_o <= 1'b0;
      hi_o       <= '0;
      lo_o       <= '0;
      cnt        <= '0;
      is_div     <= 1'b0;
      neg_res    <= 1'b0;
      neg_rem    <= 1'b0;
      opnd       <= '0;
      upper      <= '0;
      lower      <= '0;
    end else begin
      done_o     <= 1'b0;
      div_zero_o <= 1'b0;
      case (state)
        RUN: begin
          if (flush_i) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end else begin
            upper <= nxt_upper;
            lower <= nxt_lower;
            cnt   <= cnt + CW'(1);
            if (cnt == CW'(WIDTH - 1)) begin
              state  <= DONE;
              busy_o <= 1'b0;
              done_o <= 1'b1;
              if (is_div) begin
                hi_o <= rem;
                lo_o <= quo;
              end else begin
                hi_o <= prod[2*WIDTH-1:WIDTH];
                lo_o <= prod[WIDTH-1:0];
              end
            end
          end
        end
        default: begin
          if (accept) begin
            cnt     <= '0;
            is_div  <= op_i[1];
            neg_res <= a_neg ^ b_neg;
            neg_rem <= a_neg;
            upper   <= '0;
            if (div0) begin
              state      <= DONE;
              done_o     <= 1'b1;
              div_zero_o <= 1'b1;
              hi_o       <= a_i;
              lo_o       <= '1;
            end else begin
              state  <= RUN;
              busy_o <= 1'b1;
              if (op_i[1]) begin
                opnd  <= b_mag;
                lower <= a_mag;
              end else begin
                opnd  <= a_mag;
                lower <= b_mag;
              end
            end
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        start32, flush32, stall32, busy32, done32, dz32;
  logic [1:0]  op32;
  logic [31:0] a32, b32, hi32, lo32;

  logic        start8, flush8, stall8, busy8, done8, dz8;
  logic [1:0]  op8;
  logic [7:0]  a8, b8, hi8, lo8;

  muldiv_unit #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .start_i(start32), .op_i(op32), .a_i(a32), .b_i(b32),
    .flush_i(flush32), .stall_o(stall32), .busy_o(busy32), .done_o(done32),
    .hi_o(hi32), .lo_o(lo32), .div_zero_o(dz32)
  );

  muldiv_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start_i(start8), .op_i(op8), .a_i(a8), .b_i(b8),
    .flush_i(flush8), .stall_o(stall8), .busy_o(busy8), .done_o(done8),
    .hi_o(hi8), .lo_o(lo8), .div_zero_o(dz8)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          cyc;
    int          lat;
  } exp_t;

  exp_t q32[$];
  exp_t q8[$];
  exp_t e32, e8;
  int   done_cyc32[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  logic [31:0] mh, ml;
  logic        md;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic void model(input int w, input logic [1:0] op, input logic [31:0] a,
                                input logic [31:0] b, output logic [31:0] hi,
                                output logic [31:0] lo, output logic dz);
    logic [63:0]        mask, p;
    logic signed [31:0] ta, tb;
    longint             sa, sb, q, r;
    mask = (64'd1 << w) - 64'd1;
    ta = a << (32 - w);
    ta = ta >>> (32 - w);
    tb = b << (32 - w);
    tb = tb >>> (32 - w);
    sa = ta;
    sb = tb;
    dz = 1'b0;
    if (op[1] && b == 32'd0) begin
      dz = 1'b1;
      hi = a;
      lo = 32'(mask);
    end else if (!op[1]) begin
      if (op[0]) p = {32'd0, a} * {32'd0, b};
      else       p = sa * sb;
      hi = 32'((p >> w) & mask);
      lo = 32'(p & mask);
    end else begin
      if (op[0]) begin
        q = longint'({32'd0, a} / {32'd0, b});
        r = longint'({32'd0, a} % {32'd0, b});
      end else begin
        q = sa / sb;
        r = sa % sb;
      end
      hi = 32'(r & longint'(mask));
      lo = 32'(q & longint'(mask));
    end
  endfunction

  always @(negedge clk) begin
    if (rst === 1'b1 && done32 === 1'b1) begin
      done_cyc32.push_back(cyc);
      if (q32.size() == 0) begin
        check("unexpected_done32", 64'(done32), 64'd0);
      end else begin
        e32 = q32.pop_front();
        check("res32_hi", 64'(hi32), 64'(e32.hi));
        check("res32_lo", 64'(lo32), 64'(e32.lo));
        check("res32_dz", 64'(dz32), 64'(e32.dz));
        check("res32_latency", 64'(cyc - e32.cyc), 64'(e32.lat));
      end
    end
    if (rst === 1'b1 && done8 === 1'b1) begin
      if (q8.size() == 0) begin
        check("unexpected_done8", 64'(done8), 64'd0);
      end else begin
        e8 = q8.pop_front();
        check("res8_hi", 64'(hi8), 64'(e8.hi));
        check("res8_lo", 64'(lo8), 64'(e8.lo));
        check("res8_dz", 64'(dz8), 64'(e8.dz));
        check("res8_latency", 64'(cyc - e8.cyc), 64'(e8.lat));
      end
    end
  end

  task automatic issue32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] hi, input logic [31:0] lo, input logic dz,
                         input bit push, input string tag);
    exp_t e;
    int   n;
    n = 0;
    while (busy32 === 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ready"}, 64'(busy32), 64'd0);
    start32 = 1'b1;
    op32    = op;
    a32     = a;
    b32     = b;
    if (push) begin
      e.hi  = hi;
      e.lo  = lo;
      e.dz  = dz;
      e.cyc = cyc;
      e.lat = dz ? 1 : 33;
      q32.push_back(e);
    end
    #1;
    check({tag, "_stall_accept"}, 64'(stall32), 64'd1);
    @(negedge clk);
    start32 = 1'b0;
    #1;
  endtask

  task automatic issue8(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    exp_t        e;
    int          n;
    logic [31:0] h, l;
    logic        d;
    n = 0;
    while (busy8 === 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("r8_ready", 64'(busy8), 64'd0);
    model(8, op, {24'd0, a}, {24'd0, b}, h, l, d);
    start8 = 1'b1;
    op8    = op;
    a8     = a;
    b8     = b;
    e.hi   = h;
    e.lo   = l;
    e.dz   = d;
    e.cyc  = cyc;
    e.lat  = d ? 1 : 9;
    q8.push_back(e);
    @(negedge clk);
    start8 = 1'b0;
    #1;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((q32.size() != 0 || q8.size() != 0) && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    check({tag, "_drain"}, 64'(q32.size() + q8.size()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] rop;
    logic [7:0] ra, rb;
    int         n;

    rst = 1'b0;
    start32 = 1'b0; flush32 = 1'b0; op32 = 2'b00; a32 = '0; b32 = '0;
    start8  = 1'b0; flush8  = 1'b0; op8  = 2'b00; a8  = '0; b8  = '0;
    repeat (3) @(negedge clk);
    check("reset_hi", 64'(hi32), 64'd0);
    check("reset_lo", 64'(lo32), 64'd0);
    check("reset_done", 64'(done32), 64'd0);
    check("reset_busy", 64'(busy32), 64'd0);
    check("reset_dz", 64'(dz32), 64'd0);
    check("reset_stall", 64'(stall32), 64'd0);
    rst = 1'b1;
    @(negedge clk);

    issue32(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b1, "multu_max");
    for (int i = 1; i <= 32; i++) begin
      check("multu_max_stall_run", 64'(stall32), 64'd1);
      check("multu_max_busy_run", 64'(busy32), 64'd1);
      @(negedge clk);
      #1;
    end
    check("multu_max_stall_done", 64'(stall32), 64'd0);
    check("multu_max_done", 64'(done32), 64'd1);
    drain("multu_max");

    issue32(2'b00, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 1'b1, "mult_neg");
    drain("mult_neg");
    issue32(2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b1, "div_neg");
    drain("div_neg");
    issue32(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0, 1'b1, "div_ovf");
    drain("div_ovf");
    issue32(2'b11, 32'd100, 32'd0, 32'd100, 32'hFFFFFFFF, 1'b1, 1'b1, "divu_zero");
    check("divu_zero_busy", 64'(busy32), 64'd0);
    drain("divu_zero");

    issue32(2'b01, 32'd7, 32'd9, 32'd0, 32'd0, 1'b0, 1'b0, "multu_flush");
    repeat (9) @(negedge clk);
    flush32 = 1'b1;
    @(negedge clk);
    flush32 = 1'b0;
    #1;
    check("flush_busy", 64'(busy32), 64'd0);
    check("flush_hi_held", 64'(hi32), 64'd100);
    check("flush_lo_held", 64'(lo32), 64'hFFFFFFFF);
    start32 = 1'b1; flush32 = 1'b1; op32 = 2'b01; a32 = 32'd5; b32 = 32'd5;
    #1;
    check("flush_start_stall", 64'(stall32), 64'd0);
    @(negedge clk);
    start32 = 1'b0; flush32 = 1'b0;
    #1;
    check("flush_start_busy", 64'(busy32), 64'd0);
    repeat (40) @(negedge clk);
    check("flush_hi_still", 64'(hi32), 64'd100);
    issue32(2'b11, 32'd9, 32'd4, 32'd1, 32'd2, 1'b0, 1'b1, "divu_9_4");
    drain("divu_9_4");

    model(32, 2'b01, 32'h12345678, 32'h9ABCDEF0, mh, ml, md);
    issue32(2'b01, 32'h12345678, 32'h9ABCDEF0, mh, ml, md, 1'b1, "b2b_mul");
    n = 0;
    while (done32 !== 1'b1 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    model(32, 2'b11, 32'hDEADBEEF, 32'h00001234, mh, ml, md);
    issue32(2'b11, 32'hDEADBEEF, 32'h00001234, mh, ml, md, 1'b1, "b2b_div");
    drain("b2b");
    if (done_cyc32.size() >= 2)
      check("b2b_spacing", 64'(done_cyc32[$] - done_cyc32[$-1]), 64'd33);
    else
      check("b2b_done_count", 64'(done_cyc32.size()), 64'd2);

    issue32(2'b01, 32'd3, 32'd3, 32'd0, 32'd0, 1'b0, 1'b0, "rst_mid");
    repeat (5) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("rst_mid_hi", 64'(hi32), 64'd0);
    check("rst_mid_lo", 64'(lo32), 64'd0);
    check("rst_mid_busy", 64'(busy32), 64'd0);
    check("rst_mid_done", 64'(done32), 64'd0);
    check("rst_mid_dz", 64'(dz32), 64'd0);
    check("rst_mid_stall", 64'(stall32), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("rst_release_busy", 64'(busy32), 64'd0);
    repeat (40) @(negedge clk);

    for (int i = 0; i < 60; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      if (i % 7 == 3) rb = 8'h00;
      if (i % 11 == 5) begin
        rop = 2'b10;
        ra  = 8'h80;
        rb  = 8'hFF;
      end
      issue8(rop, ra, rb);
    end
    drain("rand8");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
